pixel_framebuffer_db: RTL and testbench
=======================================

PIXEL_FRAMEBUFFER_DB -- requirements
Module: pixel_framebuffer_db

Interface
REQ-001 SHALL have parameter AW, default 6, address width; the buffer depth is 2**AW pixels.
REQ-002 SHALL have parameter DW, default 24, pixel width; DW SHALL be a multiple of 8.
REQ-003 SHALL have parameter NPIX, default 64, pixels per frame; 1 <= NPIX <= 2**AW.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port wr_en  input  1  write strobe, back buffer.
REQ-007 SHALL have port wr_addr  input  AW  write pixel address.
REQ-008 SHALL have port wr_data  input  DW  write pixel value.
REQ-009 SHALL have port wr_be  input  DW/8  byte enables; bit i covers wr_data[8i+7:8i].
REQ-010 SHALL have port swap_req  input  1  single-cycle request to exchange front and back buffers.
REQ-011 SHALL have port start  input  1  single-cycle request to scan out one frame from the front buffer.
REQ-012 SHALL have port out_valid  output  1  out_data is valid.
REQ-013 SHALL have port out_ready  input  1  sink accepts out_data.
REQ-014 SHALL have port out_data  output  DW  streamed pixel.
REQ-015 SHALL have port out_last  output  1  marks pixel NPIX-1.
REQ-016 SHALL have port busy  output  1  frame scan-out in progress.
REQ-017 SHALL have port front_sel  output  1  index of the current front buffer.
REQ-018 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-019 SHALL contain two buffers of 2**AW x DW; only the back buffer (index !front_sel) is writable, and only the front buffer is read by scan-out.
REQ-020 SHALL, when wr_en=1, update only the byte lanes with wr_be=1 at wr_addr in the back buffer on that edge; writes are allowed in every state.
REQ-021 SHALL implement the FSM IDLE -> FETCH -> STREAM -> IDLE; start in IDLE -> FETCH; FETCH issues the read of address 0 -> STREAM; STREAM -> IDLE when pixel NPIX-1 is accepted.
REQ-022 SHALL ignore start while busy=1; busy SHALL be 1 in FETCH and STREAM.
REQ-023 SHALL assert the first out_valid exactly 2 cycles after the start edge.
REQ-024 SHALL count a transfer only when out_valid and out_ready are both 1, and SHALL emit pixels in address order 0..NPIX-1.
REQ-025 SHALL hold out_data, out_last and out_valid stable while out_valid=1 and out_ready=0; no pixel is dropped or duplicated.
REQ-026 SHALL sustain 1 pixel/cycle while out_ready=1, using a skid or prefetch register around the 1-cycle synchronous RAM read.
REQ-027 SHALL assert out_last with pixel NPIX-1 only; NPIX=1 yields one pixel with out_last=1.
REQ-028 SHALL pulse frame_done for exactly one cycle, on the cycle after the last transfer.
REQ-029 SHALL, for swap_req in IDLE, toggle front_sel on the next edge.
REQ-030 SHALL, for swap_req while busy, latch a pending flag and toggle front_sel on the cycle frame_done is asserted; multiple requests during one frame SHALL collapse to one swap.
REQ-031 SHALL, for swap_req and start in the same IDLE cycle, swap first and scan out the new front buffer.
REQ-032 SHALL, for wr_en on the same edge as a swap, write into the buffer that was back before the swap.

Reset
REQ-033 SHALL, on rst_n=0 at any time including mid-frame, immediately force the state to IDLE and set out_valid, out_last, busy, frame_done, front_sel and the pending swap flag to 0, and out_data to 0.
REQ-034 SHALL NOT reset the RAM contents; both buffers SHALL be zero-initialised for simulation only.

Structure
REQ-035 SHALL take the default AW, DW and NPIX values and the FSM state encoding from the shared package pixel_pkg.
REQ-036 SHALL instantiate one sub-module, pixel_ram_sdp: a simple dual-port RAM with byte-enable write, a registered read, and parameters AW and DW; one instance is used per buffer.

Verification
REQ-037 Reset, then write 0xA0B0C0 to addresses 0..63 of the back buffer, swap, start with out_ready=1 -> 64 pixels on consecutive cycles, first at start+2, out_last on pixel 63, frame_done one cycle later.
REQ-038 Write 0x112233 to addr 5, then write 0xFFFFFF with wr_be=3'b010 to addr 5, swap and scan -> pixel 5 = 0x11FF33.
REQ-039 Toggle out_ready randomly at 50% during a scan -> sink receives exactly NPIX pixels, in order, with no duplicates, and out_data stable while stalled.
REQ-040 Issue swap_req twice during a frame -> front_sel toggles once, on the frame_done cycle; start on the same cycle as busy=1 is ignored.
REQ-041 Assert rst_n=0 at pixel 20 -> all outputs 0 and state IDLE on the same cycle; a later start and scan returns the pre-reset RAM data unchanged.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared defaults and FSM encoding for the double-buffered pixel framebuffer.
package pixel_pkg;
  localparam int AW_DEF   = 6;
  localparam int DW_DEF   = 24;
  localparam int NPIX_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;
endpackage

// File: rtl/pixel_framebuffer_db_if.sv
// Pixel stream handshake: the framebuffer is the master, the display sink the slave.
interface pixel_framebuffer_db_if #(
  parameter int DW = pixel_pkg::DW_DEF
);
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (output out_valid, out_data, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_last, output out_ready);
endinterface

// File: rtl/pixel_ram_sdp.sv
// Simple dual-port RAM: byte-enabled write port, registered read port.
module pixel_ram_sdp #(
  parameter int AW = 6,
  parameter int DW = 24
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wbe,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);
  localparam int NB = DW / 8;

  // Zero contents at time zero only so simulation never streams X.
  logic [DW-1:0] mem [2**AW] = '{default: '0};

  // NOTE: storage arrays get no reset branch; resetting them would forbid block-RAM mapping and the contents must survive rst_n anyway.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/pixel_framebuffer_db.sv
// Double-buffered framebuffer: writes land in the back buffer, the front buffer
// streams out with valid/ready; the RAM output register acts as a prefetch stage.
module pixel_framebuffer_db
  import pixel_pkg::*;
#(
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int NPIX = NPIX_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [DW-1:0]          wr_data,
  input  logic [DW/8-1:0]        wr_be,
  input  logic                   swap_req,
  input  logic                   start,
  pixel_framebuffer_db_if.master out_if,
  output logic                   busy,
  output logic                   front_sel,
  output logic                   frame_done
);
  localparam logic [AW:0] NPIX_C = (AW+1)'(NPIX);
  localparam logic [AW:0] ONE    = (AW+1)'(1);

  state_t        state;
  logic [AW:0]   rd_ptr;
  logic          q_valid, q_last, swap_pend;
  logic [DW-1:0] q0, q1, q;
  logic          adv, load1, more, issue, last_xfer;

  always_comb begin
    adv       = !out_if.out_valid || out_if.out_ready;
    load1     = adv || !q_valid;
    more      = rd_ptr < NPIX_C;
    issue     = (state == ST_FETCH) || ((state == ST_STREAM) && load1 && more);
    last_xfer = out_if.out_valid && out_if.out_ready && out_if.out_last;
    q         = front_sel ? q1 : q0;
  end

  // Buffer 0 is writable while buffer 1 is front, and vice versa.
  pixel_ram_sdp #(.AW(AW), .DW(DW)) u_ram0 (
    .clk(clk), .we(wr_en && front_sel), .waddr(wr_addr), .wdata(wr_data), .wbe(wr_be),
    .re(issue && !front_sel), .raddr(rd_ptr[AW-1:0]), .rdata(q0)
  );

  pixel_ram_sdp #(.AW(AW), .DW(DW)) u_ram1 (
    .clk(clk), .we(wr_en && !front_sel), .waddr(wr_addr), .wdata(wr_data), .wbe(wr_be),
    .re(issue && front_sel), .raddr(rd_ptr[AW-1:0]), .rdata(q1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      rd_ptr           <= '0;
      q_valid          <= 1'b0;
      q_last           <= 1'b0;
      swap_pend        <= 1'b0;
      busy             <= 1'b0;
      front_sel        <= 1'b0;
      frame_done       <= 1'b0;
      out_if.out_valid <= 1'b0;
      out_if.out_last  <= 1'b0;
      out_if.out_data  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (swap_req) front_sel <= ~front_sel;
          if (start) begin
            state  <= ST_FETCH;
            busy   <= 1'b1;
            rd_ptr <= '0;
          end
        end
        ST_FETCH: begin
          if (swap_req) swap_pend <= 1'b1;
          rd_ptr  <= ONE;
          q_valid <= 1'b1;
          q_last  <= (NPIX == 1);
          state   <= ST_STREAM;
        end
        ST_STREAM: begin
          // The prefetch stage refills whenever the output stage drains or it is empty.
          if (load1) begin
            q_valid <= issue;
            if (issue) begin
              rd_ptr <= rd_ptr + ONE;
              q_last <= (rd_ptr == NPIX_C - ONE);
            end
          end
          if (adv) begin
            out_if.out_valid <= q_valid;
            out_if.out_last  <= q_valid && q_last;
            if (q_valid) out_if.out_data <= q;
          end
          if (swap_req) swap_pend <= 1'b1;
          if (last_xfer) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            if (swap_pend || swap_req) begin
              front_sel <= ~front_sel;
              swap_pend <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pixel_framebuffer_db.sv
// Scoreboard bench: scan stimulus pushes expected pixels, a negedge monitor pops and compares.
module tb_pixel_framebuffer_db;
  import pixel_pkg::*;
  localparam int AW = AW_DEF, DW = DW_DEF, NPIX = NPIX_DEF;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [DW-1:0]   wr_data = '0;
  logic [DW/8-1:0] wr_be = '0;
  logic            swap_req = 1'b0;
  logic            start = 1'b0;
  logic            busy, front_sel, frame_done;

  always #5 clk = ~clk;

  pixel_framebuffer_db_if #(.DW(DW)) sif ();

  pixel_framebuffer_db #(.AW(AW), .DW(DW), .NPIX(NPIX)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .swap_req(swap_req), .start(start), .out_if(sif),
    .busy(busy), .front_sel(front_sel), .frame_done(frame_done)
  );

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference model of both buffers and of which one is front.
  logic [DW-1:0] model [2][2**AW];
  logic          front_m = 1'b0;
  logic [DW:0]   exp_q [$];

  // Monitor state
  int            rx_idx = 0, frames_done = 0, first_cyc = 0, last_cyc = 0;
  logic [DW-1:0] rx5 = '0, hold_data = '0;
  logic          hold_last = 1'b0;
  bit            stall_hold = 0, done_due = 0, done_clr_due = 0;
  logic [DW:0]   exp_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_hold = 0; done_due = 0; done_clr_due = 0; rx_idx = 0;
    end else begin
      if (done_clr_due) begin check("frame_done_one_cycle", frame_done, 0); done_clr_due = 0; end
      if (done_due) begin check("frame_done_after_last", frame_done, 1); done_due = 0; done_clr_due = 1; end
      if (stall_hold)
        check("stall_stable", {sif.out_valid, sif.out_last, sif.out_data}, {1'b1, hold_last, hold_data});
      stall_hold = sif.out_valid && !sif.out_ready;
      hold_data  = sif.out_data;
      hold_last  = sif.out_last;
      if (sif.out_valid && sif.out_ready) begin
        if (exp_q.size() == 0) begin
          check("expected_queue_nonempty", exp_q.size(), 1);
        end else begin
          exp_e = exp_q.pop_front();
          check($sformatf("pixel%0d", rx_idx), {sif.out_last, sif.out_data}, exp_e);
        end
        if (rx_idx == 0) first_cyc = cyc;
        if (rx_idx == 5) rx5 = sif.out_data;
        if (sif.out_last) begin
          last_cyc = cyc; done_due = 1; frames_done++; rx_idx = 0;
        end else rx_idx++;
      end
    end
  end

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [DW/8-1:0] be, input bit do_swap);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d; wr_be = be; swap_req = do_swap;
    tick();
    wr_en = 1'b0; swap_req = 1'b0;
    for (int b = 0; b < DW/8; b++)
      if (be[b]) model[!front_m][a][8*b +: 8] = d[8*b +: 8];
    if (do_swap) begin
      front_m = ~front_m;
      check("front_sel_swap_with_write", front_sel, front_m);
    end
  endtask

  task automatic swap();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    front_m = ~front_m;
    check("front_sel_swap", front_sel, front_m);
  endtask

  function automatic logic [DW-1:0] pat(input int a, input logic [7:0] s);
    logic [7:0] b;
    b = 8'(a);
    return {b ^ s, ~b, b + s};
  endfunction

  task automatic scan(input bit full_rate, input int rst_at, input bit swap_test);
    int   f0, budget;
    bit   s1, s2, s3, chk;
    logic fs0;
    s1 = 0; s2 = 0; s3 = 0; chk = 0; budget = 0;
    for (int i = 0; i < NPIX; i++) exp_q.push_back({(i == NPIX-1), model[front_m][i]});
    f0 = frames_done; fs0 = front_sel;
    out_ready_drive(full_rate);
    start = 1'b1; tick(); start = 1'b0;
    check("busy_after_start", busy, 1);
    tick(); check("valid_at_start_plus1", sif.out_valid, 0);
    tick(); check("valid_at_start_plus2", sif.out_valid, 1);
    while (frames_done == f0 && budget < 4000) begin
      out_ready_drive(full_rate);
      if (swap_test) begin
        if (!s1 && rx_idx >= 10) begin s1 = 1; swap_req = 1'b1; end
        else if (!s2 && rx_idx >= 20) begin s2 = 1; swap_req = 1'b1; end
        else swap_req = 1'b0;
        if (!s3 && rx_idx >= 15) begin s3 = 1; start = 1'b1; end else start = 1'b0;
        if (!chk && rx_idx >= 30) begin chk = 1; check("front_hold_midframe", front_sel, fs0); end
      end
      if (rst_at >= 0 && rx_idx >= rst_at) begin
        rst_n = 1'b0; #1;
        check("rst_out_valid", sif.out_valid, 0);
        check("rst_out_last", sif.out_last, 0);
        check("rst_out_data", sif.out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_front_sel", front_sel, 0);
        exp_q.delete(); front_m = 1'b0;
        tick(); rst_n = 1'b1; tick();
        return;
      end
      tick(); budget++;
    end
    swap_req = 1'b0; start = 1'b0; sif.out_ready = 1'b1;
    check("frame_completed", frames_done - f0, 1);
    if (swap_test) front_m = ~front_m;
    check("front_sel_at_frame_done", front_sel, front_m);
    if (full_rate) check("full_rate_span", last_cyc - first_cyc, NPIX - 1);
    repeat (4) tick();
    check("busy_clear", busy, 0);
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic out_ready_drive(input bit full_rate);
    sif.out_ready = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 2**AW; a++) model[k][a] = '0;
    sif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", sif.out_valid, 0);
    check("reset_out_last", sif.out_last, 0);
    check("reset_out_data", sif.out_data, 0);
    check("reset_busy", busy, 0);
    check("reset_front_sel", front_sel, 0);
    check("reset_frame_done", frame_done, 0);
    rst_n = 1'b1; tick();

    // Uniform frame at full rate.
    for (int a = 0; a < NPIX; a++) wr(a, 24'hA0B0C0, 3'b111, 0);
    swap();
    scan(1, -1, 0);

    // Byte-lane merge on address 5.
    wr(5, 24'h112233, 3'b111, 0);
    wr(5, 24'hFFFFFF, 3'b010, 0);
    swap();
    scan(1, -1, 0);
    check("byte_lane_merge", rx5, 24'h11FF33);

    // Patterned frame, last write on the swap edge, random backpressure.
    for (int a = 0; a < NPIX - 1; a++) wr(a, pat(a, 8'h3C), 3'b111, 0);
    wr(NPIX - 1, pat(NPIX - 1, 8'h3C), 3'b111, 1);
    scan(0, -1, 0);

    // Two swap requests and an ignored start during one frame.
    for (int a = 0; a < NPIX; a++) wr(a, pat(a, 8'h95), 3'b111, 0);
    scan(1, -1, 1);

    // Reset mid-frame, then confirm both buffers kept their data.
    swap();
    scan(1, 20, 0);
    scan(1, -1, 0);
    swap();
    scan(0, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
